// File: rtl/uart_pkg.sv
// ----------------------------------------------------------------------------
// uart_pkg: shared UART types, widths and baud-divider helper. Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package uart_pkg;

  localparam int UART_DATA_W = 8;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    START     = 3'd1,
    DATA      = 3'd2,
    PARITY    = 3'd3,
    STOP      = 3'd4,
    WAIT_HIGH = 3'd5
  } rx_state_e;

  function automatic int cycles_per_bit(input int clk_mhz, input int baud);
    return (clk_mhz * 1000000) / baud;
  endfunction

endpackage

`default_nettype wire

// File: rtl/uart_rx_sync.sv
// ----------------------------------------------------------------------------
// uart_rx_sync: 2-flop synchronizer for an asynchronous input. Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module uart_rx_sync #(
  parameter logic RESET_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      meta_q <= RESET_VAL;
      sync_q <= RESET_VAL;
    end else begin
      meta_q <= d;
      sync_q <= meta_q;
    end
  end

  assign q = sync_q;

endmodule

`default_nettype wire

// File: rtl/uart_rx.sv
// ----------------------------------------------------------------------------
// uart_rx: 8N1 UART receiver with valid/ready output, framing/overrun flags.
// Optional parity check when UART_RX_PARITY_EN is defined. Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module uart_rx
  import uart_pkg::*;
#(
  parameter int CLK_FRE   = 27,
  parameter int BAUD_RATE = 115200
`ifdef UART_RX_PARITY_EN
  ,parameter logic PARITY_ODD = 1'b0
`endif
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   rx_pin,
  output logic [UART_DATA_W-1:0] rx_data,
  output logic                   rx_data_valid,
  input  logic                   rx_data_ready,
  output logic                   frame_err,
  output logic                   overrun
`ifdef UART_RX_PARITY_EN
  ,output logic                  parity_err
`endif
);

  localparam int CYCLES_PER_BIT = cycles_per_bit(CLK_FRE, BAUD_RATE);
  localparam int HALF_BIT       = CYCLES_PER_BIT / 2;
  localparam int CNT_W          = $clog2(CYCLES_PER_BIT);
  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CYCLES_PER_BIT - 1);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(HALF_BIT - 1);

  logic                   rx_s;
  rx_state_e              state_q, state_d;
  logic [CNT_W-1:0]       cyc_q, cyc_d;
  logic [3:0]             bit_q, bit_d;
  logic [UART_DATA_W-1:0] shift_q, shift_d;
  logic [UART_DATA_W-1:0] rx_data_q, rx_data_d;
  logic                   valid_q, valid_d;
  logic                   frame_err_q, frame_err_d;
  logic                   overrun_q, overrun_d;
  logic                   deliver;
`ifdef UART_RX_PARITY_EN
  logic                   par_q, par_d;
  logic                   parity_err_q, parity_err_d;
`endif

  uart_rx_sync #(.RESET_VAL(1'b1)) u_sync (
    .clk (clk),
    .rst (rst),
    .d   (rx_pin),
    .q   (rx_s)
  );

  always_comb begin
    state_d     = state_q;
    cyc_d       = cyc_q + 1'b1;
    bit_d       = bit_q;
    shift_d     = shift_q;
    rx_data_d   = rx_data_q;
    valid_d     = valid_q & ~rx_data_ready;
    frame_err_d = 1'b0;
    overrun_d   = 1'b0;
    deliver     = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_d        = par_q;
    parity_err_d = 1'b0;
`endif

    case (state_q)
      IDLE: begin
        cyc_d = '0;
        if (!rx_s) state_d = START;
      end
      START: begin
        if (cyc_q == HALF_LAST) begin
          cyc_d   = '0;
          bit_d   = 4'd0;
          state_d = rx_s ? IDLE : DATA;
        end
      end
      DATA: begin
        if (cyc_q == BIT_LAST) begin
          cyc_d   = '0;
          shift_d = {rx_s, shift_q[UART_DATA_W-1:1]};
          bit_d   = bit_q + 4'd1;
          if (bit_q == 4'd7) begin
`ifdef UART_RX_PARITY_EN
            state_d = PARITY;
`else
            state_d = STOP;
`endif
          end
        end
      end
`ifdef UART_RX_PARITY_EN
      PARITY: begin
        if (cyc_q == BIT_LAST) begin
          cyc_d   = '0;
          par_d   = rx_s;
          state_d = STOP;
        end
      end
`endif
      STOP: begin
        if (cyc_q == BIT_LAST) begin
          cyc_d = '0;
`ifdef UART_RX_PARITY_EN
          parity_err_d = ((^shift_q) ^ par_q) != PARITY_ODD;
`endif
          if (rx_s) begin
            deliver = 1'b1;
            state_d = IDLE;
          end else begin
            frame_err_d = 1'b1;
            state_d     = WAIT_HIGH;
          end
        end
      end
      WAIT_HIGH: begin
        cyc_d = '0;
        if (rx_s) state_d = IDLE;
      end
      default: begin
        cyc_d   = '0;
        state_d = IDLE;
      end
    endcase

    // A byte accepted in the same cycle frees the holding register for the new one.
    if (deliver) begin
      if (!valid_q || rx_data_ready) begin
        rx_data_d = shift_q;
        valid_d   = 1'b1;
      end else begin
        overrun_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      cyc_q       <= '0;
      bit_q       <= 4'd0;
      shift_q     <= '0;
      rx_data_q   <= '0;
      valid_q     <= 1'b0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cyc_q       <= cyc_d;
      bit_q       <= bit_d;
      shift_q     <= shift_d;
      rx_data_q   <= rx_data_d;
      valid_q     <= valid_d;
      frame_err_q <= frame_err_d;
      overrun_q   <= overrun_d;
    end
  end

`ifdef UART_RX_PARITY_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      par_q        <= 1'b0;
      parity_err_q <= 1'b0;
    end else begin
      par_q        <= par_d;
      parity_err_q <= parity_err_d;
    end
  end

  assign parity_err = parity_err_q;
`endif

  assign rx_data       = rx_data_q;
  assign rx_data_valid = valid_q;
  assign frame_err     = frame_err_q;
  assign overrun       = overrun_q;

endmodule

`default_nettype wire

// File: tb/tb_uart_rx.sv
// ----------------------------------------------------------------------------
// tb_uart_rx: self-checking bench for uart_rx (table vectors + scoreboard). Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tb_uart_rx;
  import uart_pkg::*;

  localparam int CPB = 234;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rx_pin = 1'b1;
  logic [7:0] rx_data;
  logic       rx_data_valid;
  logic       rx_data_ready = 1'b1;
  logic       frame_err;
  logic       overrun;
`ifdef UART_RX_PARITY_EN
  logic       parity_err;
`endif

  always #5 clk = ~clk;

  uart_rx dut (
    .clk           (clk),
    .rst           (rst),
    .rx_pin        (rx_pin),
    .rx_data       (rx_data),
    .rx_data_valid (rx_data_valid),
    .rx_data_ready (rx_data_ready),
    .frame_err     (frame_err),
    .overrun       (overrun)
`ifdef UART_RX_PARITY_EN
    ,.parity_err   (parity_err)
`endif
  );

  int total = 0;
  int bad   = 0;

  // Monitor: observed handshakes and pulse counts; only this block writes them.
  int         n_valid = 0;
  int         n_ferr  = 0;
  int         n_ovr   = 0;
  int         n_perr  = 0;
  logic [7:0] obs_q [$];

  always @(negedge clk) begin
    if (!rst) begin
      if (rx_data_valid) n_valid = n_valid + 1;
      if (frame_err)     n_ferr  = n_ferr + 1;
      if (overrun)       n_ovr   = n_ovr + 1;
`ifdef UART_RX_PARITY_EN
      if (parity_err)    n_perr  = n_perr + 1;
`endif
      if (rx_data_valid && rx_data_ready) obs_q.push_back(rx_data);
    end
  end

  logic [7:0] exp_q [$];
  int         rd_idx = 0;

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic drain();
    logic [7:0] e;
    while (rd_idx < obs_q.size()) begin
      if (exp_q.size() == 0) begin
        check("sb_unexpected_byte", int'(obs_q[rd_idx]), -1);
      end else begin
        e = exp_q.pop_front();
        check("sb_byte", int'(obs_q[rd_idx]), int'(e));
      end
      rd_idx++;
    end
  endtask

  task automatic drive(input logic v, input int n);
    rx_pin = v;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_frame(input logic [7:0] d, input int stop_low, input logic par_bit);
    drive(1'b0, CPB);
    for (int i = 0; i < 8; i++) drive(d[i], CPB);
`ifdef UART_RX_PARITY_EN
    drive(par_bit, CPB);
`else
    if (par_bit) begin end
`endif
    if (stop_low > 0) drive(1'b0, stop_low * CPB);
    drive(1'b1, CPB);
  endtask

  typedef struct {
    logic [7:0] data;
    int         stop_low;
    int         exp_valid;
    int         exp_ferr;
  } vec_t;

  vec_t vecs [6];

  int v0, f0, o0, p0;

  initial begin
    vecs[0] = '{8'hA3, 0, 1, 0};
    vecs[1] = '{8'h55, 0, 1, 0};
    vecs[2] = '{8'h0F, 3, 0, 1};
    vecs[3] = '{8'h11, 0, 1, 0};
    vecs[4] = '{8'h00, 0, 1, 0};
    vecs[5] = '{8'hFF, 0, 1, 0};

    repeat (5) begin
      @(posedge clk);
      #1;
    end
    check("reset_rx_data", int'(rx_data), 0);
    check("reset_valid", int'(rx_data_valid), 0);
    check("reset_frame_err", int'(frame_err), 0);
    check("reset_overrun", int'(overrun), 0);
    rst = 1'b0;
    drive(1'b1, 4);

    // Short low glitch must be rejected at the start-bit midpoint.
    v0 = n_valid; f0 = n_ferr;
    drive(1'b0, 50);
    drive(1'b1, 2 * CPB);
    check("glitch_no_valid", n_valid - v0, 0);
    check("glitch_no_ferr", n_ferr - f0, 0);
    check("glitch_state_idle", int'(dut.state_q), int'(IDLE));

    for (int i = 0; i < 6; i++) begin
      v0 = n_valid; f0 = n_ferr; o0 = n_ovr;
      if (vecs[i].exp_valid != 0) exp_q.push_back(vecs[i].data);
      send_frame(vecs[i].data, vecs[i].stop_low, ^vecs[i].data);
      drive(1'b1, CPB);
      check($sformatf("vec%0d_valid_cycles", i), n_valid - v0, vecs[i].exp_valid);
      check($sformatf("vec%0d_frame_err", i), n_ferr - f0, vecs[i].exp_ferr);
      check($sformatf("vec%0d_overrun", i), n_ovr - o0, 0);
      drain();
    end

    // Overrun: holding register full, second back-to-back byte is lost.
    rx_data_ready = 1'b0;
    o0 = n_ovr; f0 = n_ferr;
    exp_q.push_back(8'h12);
    send_frame(8'h12, 0, ^8'h12);
    send_frame(8'h34, 0, ^8'h34);
    drive(1'b1, CPB);
    check("ovr_pulses", n_ovr - o0, 1);
    check("ovr_rx_data_held", int'(rx_data), 'h12);
    check("ovr_valid_held", int'(rx_data_valid), 1);
    check("ovr_no_ferr", n_ferr - f0, 0);
    rx_data_ready = 1'b1;
    drive(1'b1, 2);
    check("ovr_valid_dropped", int'(rx_data_valid), 0);
    drain();

    // Reset in the middle of data bit 4 of 0xC3.
    v0 = n_valid;
    drive(1'b0, CPB);
    for (int i = 0; i < 4; i++) drive(logic'((8'hC3 >> i) & 8'h01), CPB);
    drive(1'b0, CPB / 2);
    rx_pin = 1'b1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("midrst_rx_data", int'(rx_data), 0);
    check("midrst_valid", int'(rx_data_valid), 0);
    check("midrst_state", int'(dut.state_q), int'(IDLE));
    rst = 1'b0;
    drive(1'b1, 2 * CPB);
    check("midrst_no_byte", n_valid - v0, 0);
    v0 = n_valid;
    exp_q.push_back(8'h7E);
    send_frame(8'h7E, 0, ^8'h7E);
    drive(1'b1, CPB);
    check("post_rst_valid", n_valid - v0, 1);
    drain();

`ifdef UART_RX_PARITY_EN
    p0 = n_perr; v0 = n_valid;
    exp_q.push_back(8'h01);
    send_frame(8'h01, 0, 1'b0);
    drive(1'b1, CPB);
    check("par_bad_perr", n_perr - p0, 1);
    check("par_bad_valid", n_valid - v0, 1);
    drain();
    p0 = n_perr;
    exp_q.push_back(8'h01);
    send_frame(8'h01, 0, 1'b1);
    drive(1'b1, CPB);
    check("par_good_perr", n_perr - p0, 0);
    drain();
`else
    p0 = n_perr;
`endif

    check("sb_all_received", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
